decode_stage: RTL
=================

Name: decode_stage

Overview:
- Second stage of the 16-bit RISC pipeline, directly downstream of instruction fetch.
- Registers the fetched instruction and PC, splits them into fields and sign-extends the immediates.
- Expands LM/SM into one micro-op per selected register, back-pressuring fetch while it does so.
- Feeds the register-read stage with one decoded op per cycle; latency 1 cycle.

Parameters:
- ADDR_STEP, 2, address increment added to the micro-op offset per transferred register.
- PC_W, 16, width of PC in and out.

Ports:
- clock  in  1  pipeline clock, all state on posedge.
- reset_n  in  1  synchronous active-low reset.
- instr_in  in  16  instruction from fetch.
- pc_in  in  PC_W  PC of instr_in.
- valid_in  in  1  instr_in holds a real instruction.
- stall_in  in  1  downstream hazard stall; hold everything.
- flush  in  1  branch/jump redirect; kill the current op.
- stall_fetch  out  1  fetch must hold instr_in/pc_in (combinational).
- valid_out  out  1  decoded op is valid.
- instr_out  out  16  registered instruction.
- pc_out  out  PC_W  registered PC.
- opcode  out  4  instr[15:12].
- ra, rb, rc  out  3 each  instr[11:9], [8:6], [5:3].
- comp  out  1  instr[2].
- cz  out  2  instr[1:0].
- imm6  out  16  sign-extended instr[5:0].
- imm9  out  16  sign-extended instr[8:0].
- is_uop  out  1  output is an LM/SM micro-op.
- uop_reg  out  3  register transferred by the micro-op.
- uop_offset  out  16  ADDR_STEP × micro-op index.
- uop_last  out  1  final micro-op of its LM/SM.
- illegal  out  1  illegal opcode flag (see optional feature).

Behaviour:
- Reset (reset_n=0 at posedge): all outputs registered to 0, state=IDLE, remaining list=0. This overrides flush and stall_in.
- Opcodes:
  - 0000 ADI, 0001 ADD-group, 0010 NAND-group, 0011 LLI, 0100 LW, 0101 SW.
  - 0110 LM, 0111 SM.
  - 1000 BEQ, 1001 BLT, 1010 BLE, 1100 JAL, 1101 JLR, 1111 JRI.
  - 1011 and 1110 are illegal.
- LM/SM register list is instr[7:0]; bit 7 selects R0 and bit 0 selects R7.
- IDLE, non-LM/SM, valid_in=1: next edge registers all fields, valid_out=1, is_uop=0.
- IDLE, valid_in=0: next edge gives valid_out=0. Field outputs still track instr_in (don't-care).
- IDLE, LM/SM with list≠0:
  - The first micro-op is output next edge: uop_reg is the lowest register index set, uop_offset=0, is_uop=1, valid_out=1.
  - If popcount=1: uop_last=1 and state stays IDLE.
  - Otherwise state→MULTI and the remaining list is captured minus the emitted bit.
- LM/SM with list=0: one valid_out=1 op, is_uop=1, uop_reg=0, uop_last=1, write/memory suppressed downstream via is_uop with an empty list. Emitted as a no-op, no stall.
- MULTI: each unstalled edge emits the next lowest set register, with uop_offset increased by ADDR_STEP (16-bit wrap) and the same instr_out/pc_out. On the last bit: uop_last=1 and state→IDLE.
- stall_fetch = stall_in OR (IDLE and valid_in and LM/SM and popcount≥2) OR (MULTI and remaining popcount≥2).
  - An N-register LM/SM therefore holds fetch for N−1 cycles (absent stall_in).
  - The next instruction is accepted on the edge that emits the last micro-op.
- stall_in=1 (and no flush): all outputs, state, remaining list and offset are held.
- flush=1: next edge gives valid_out=0, is_uop=0, uop_last=0, state→IDLE, remaining list cleared. This aborts a MULTI sequence mid-way, and flush beats stall_in. instr_in is not consumed on a flush edge.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: opcode 1011/1110 with valid_in gives illegal=1 and valid_out=0 next edge. illegal is held under stall_in and cleared by flush/reset or the next accepted op.
- Undefined: illegal is tied to 0 and illegal opcodes pass with valid_out=1 like any other op.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with valid_in=1, instr_in=16'h1234 -> all outputs 0, stall_fetch=0.
- ADD: instr 0001001010100000, pc 5 -> after 1 edge opcode=1, ra=1, rb=2, rc=4, comp=0, cz=00, pc_out=5, valid_out=1.
- Immediates: BEQ 1000101101000111 -> imm6=16'h0007. Instr 0000xxx111111111 -> imm9=16'hFFFF, imm6=16'hFFFF.
- LM: 0110100000000011 -> stall_fetch=1 for 1 cycle; micro-ops (R6, off 0, last 0) then (R7, off 2, last 1); the next instruction appears on the following edge.
- Stall and flush: LM with list 8'hFF, stall_in asserted during the 3rd micro-op for 2 cycles, then flush -> the 3rd micro-op (R2, off 4) is held; after flush valid_out=0, state IDLE, stall_fetch=0.
- Illegal (macro defined): instr 1110000000000000 -> illegal=1, valid_out=0. Macro undefined -> illegal=0, valid_out=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: second pipeline stage of the 16-bit RISC core.
// Registers the fetched instruction/PC, exposes its fields and sign-extended
// immediates, and expands LM/SM into one micro-op per selected register while
// holding fetch.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal opcodes 1011/1110
// raise 'illegal' and are dropped instead of passing as valid ops).
module decode_stage #(
  parameter int ADDR_STEP = 2,
  parameter int PC_W      = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [15:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            valid_in,
  input  logic            stall_in,
  input  logic            flush,
  output logic            stall_fetch,
  output logic            valid_out,
  output logic [15:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      opcode,
  output logic [2:0]      ra,
  output logic [2:0]      rb,
  output logic [2:0]      rc,
  output logic            comp,
  output logic [1:0]      cz,
  output logic [15:0]     imm6,
  output logic [15:0]     imm9,
  output logic            is_uop,
  output logic [2:0]      uop_reg,
  output logic [15:0]     uop_offset,
  output logic            uop_last,
  output logic            illegal
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, MULTI} state_t;

  state_t      state;
  logic [7:0]  remaining;   // registers still to transfer; bit 7 = R0, bit 0 = R7
  logic        illegal_q;

  logic [7:0]  list_cur;
  logic [7:0]  first_bit;
  logic [7:0]  list_rest;
  logic [2:0]  first_reg;
  logic        multi_needed;
  logic        is_lmsm_in;
  logic        illegal_op_in;

  assign is_lmsm_in    = (instr_in[15:13] == 3'b011);
  assign illegal_op_in = (instr_in[15:12] == 4'b1011) || (instr_in[15:12] == 4'b1110);

  // Pick the lowest-numbered register (highest list bit) from the active list.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    list_cur  = (state == MULTI) ? remaining : instr_in[7:0];
    first_reg = 3'd0;
    first_bit = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (list_cur[i]) begin
        first_reg    = 3'(7 - i);
        first_bit    = 8'd0;
        first_bit[i] = 1'b1;
      end
    end
    list_rest    = list_cur & ~first_bit;
    multi_needed = ($countones(list_cur) >= 2);
  end

  // Fetch must hold while more micro-ops remain after the one emitted next edge.
  assign stall_fetch = stall_in
                     | ((state == IDLE) & valid_in & is_lmsm_in & multi_needed)
                     | ((state == MULTI) & multi_needed);

  // Pipeline register and LM/SM sequencer; reset > flush > stall > advance.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      valid_out  <= 1'b0;
      instr_out  <= 16'd0;
      pc_out     <= '0;
      is_uop     <= 1'b0;
      uop_reg    <= 3'd0;
      uop_offset <= 16'd0;
      uop_last   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      valid_out  <= 1'b0;
      is_uop     <= 1'b0;
      uop_last   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!stall_in) begin
      if (state == MULTI) begin
        // Next micro-op of the same LM/SM; instruction and PC stay put.
        valid_out  <= 1'b1;
        is_uop     <= 1'b1;
        uop_reg    <= first_reg;
        uop_offset <= uop_offset + 16'(ADDR_STEP);
        uop_last   <= !multi_needed;
        remaining  <= list_rest;
        illegal_q  <= 1'b0;
        if (!multi_needed) state <= IDLE;
      end else begin
        instr_out  <= instr_in;
        pc_out     <= pc_in;
        uop_offset <= 16'd0;
        illegal_q  <= TRAP_EN & valid_in & illegal_op_in;
        valid_out  <= valid_in & !(TRAP_EN & illegal_op_in);
        if (valid_in && is_lmsm_in) begin
          // An empty list yields a single no-op micro-op with uop_reg = 0.
          is_uop   <= 1'b1;
          uop_reg  <= first_reg;
          uop_last <= !multi_needed;
          if (multi_needed) begin
            state     <= MULTI;
            remaining <= list_rest;
          end
        end else begin
          is_uop   <= 1'b0;
          uop_reg  <= 3'd0;
          uop_last <= 1'b0;
        end
      end
    end
  end

  // Field split and sign extension are pure wiring off the registered word.
  assign opcode  = instr_out[15:12];
  assign ra      = instr_out[11:9];
  assign rb      = instr_out[8:6];
  assign rc      = instr_out[5:3];
  assign comp    = instr_out[2];
  assign cz      = instr_out[1:0];
  assign imm6    = {{10{instr_out[5]}}, instr_out[5:0]};
  assign imm9    = {{7{instr_out[8]}}, instr_out[8:0]};
  assign illegal = TRAP_EN ? illegal_q : 1'b0;

endmodule
